// File: rtl/hms_pkg.sv
// Shared encodings and field limits for the HH:MM:SS timekeeper.
package hms_pkg;

  localparam int unsigned FIELD_W = 6;
  typedef logic [FIELD_W-1:0] field_t;

  localparam logic [1:0] MODE_CLOCK = 2'd0;
  localparam logic [1:0] MODE_SETUP = 2'd1;
  localparam logic [1:0] MODE_TIMER = 2'd2;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  localparam field_t SEC_MAX = 6'd59;
  localparam field_t MIN_MAX = 6'd59;

endpackage

// File: rtl/mod_cnt.sv
// 6-bit modulo up/down counter; o_wrap flags the wrap (up) or borrow (down) step.
module mod_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_max,
  input  logic       i_up,
  input  logic       i_dn,
  output logic [5:0] o_val,
  output logic       o_wrap
);
  import hms_pkg::*;

  // Combinational so carries ripple through every field within one cycle.
  assign o_wrap = (i_up & (o_val == i_max)) | (~i_up & i_dn & (o_val == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_val <= '0;
    end else if (i_up) begin
      o_val <= (o_val == i_max) ? '0 : o_val + 6'd1;
    end else if (i_dn) begin
      o_val <= (o_val == '0) ? i_max : o_val - 6'd1;
    end
  end

endmodule

// File: rtl/hms_clock_core.sv
// HH:MM:SS clock with setup and countdown-timer modes, tick-enable based, single clock.
module hms_clock_core #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned BUZZ_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_pls,
  input  logic       i_pos_pls,
  input  logic       i_inc_pls,
  input  logic       i_run_pls,
  output logic [5:0] o_disp_h,
  output logic [5:0] o_disp_m,
  output logic [5:0] o_disp_s,
  output logic [1:0] o_mode,
  output logic [1:0] o_pos,
  output logic       o_run,
  output logic       o_buzz
);
  import hms_pkg::*;

  localparam int unsigned DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BUZ_W = $clog2(BUZZ_SEC + 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [BUZ_W-1:0] buzz_left;

  field_t c_sec, c_min, c_hour, t_sec, t_min;
  logic   c_sec_wrap, c_min_wrap, c_hour_wrap, t_sec_wrap, t_min_wrap;
  logic   unused_wraps;

  logic run_ev, pos_ev, inc_ev, any_pls;
  logic clk_adv, set_inc, tmr_edit, tmr_inc, t_dec, t_zero, expire;

  assign tick = (div_q == DIV_W'(CLK_HZ - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Mode pulse masks everything else; remaining pulses resolve run > pos > inc.
  assign run_ev  = i_run_pls & ~i_mode_pls;
  assign pos_ev  = i_pos_pls & ~i_mode_pls & ~i_run_pls;
  assign inc_ev  = i_inc_pls & ~i_mode_pls & ~i_run_pls & ~i_pos_pls;
  assign any_pls = i_mode_pls | i_pos_pls | i_inc_pls | i_run_pls;

  assign clk_adv  = tick & (o_mode != MODE_SETUP);
  assign set_inc  = inc_ev & (o_mode == MODE_SETUP);
  assign tmr_edit = (o_mode == MODE_TIMER) & ~o_run;
  assign tmr_inc  = inc_ev & tmr_edit;
  assign t_dec    = o_run & tick;
  assign t_zero   = (t_min == '0) & (t_sec == '0);
  assign expire   = t_dec & (t_min == '0) & (t_sec == 6'd1);

  mod_cnt u_c_sec (.clk(clk), .rst_n(rst_n), .i_max(SEC_MAX),
    .i_up(clk_adv | (set_inc & (o_pos == POS_SEC))), .i_dn(1'b0),
    .o_val(c_sec), .o_wrap(c_sec_wrap));
  mod_cnt u_c_min (.clk(clk), .rst_n(rst_n), .i_max(MIN_MAX),
    .i_up((clk_adv & c_sec_wrap) | (set_inc & (o_pos == POS_MIN))), .i_dn(1'b0),
    .o_val(c_min), .o_wrap(c_min_wrap));
  mod_cnt u_c_hour (.clk(clk), .rst_n(rst_n), .i_max(6'(HOUR_MAX)),
    .i_up((clk_adv & c_sec_wrap & c_min_wrap) | (set_inc & (o_pos == POS_HOUR))), .i_dn(1'b0),
    .o_val(c_hour), .o_wrap(c_hour_wrap));
  mod_cnt u_t_sec (.clk(clk), .rst_n(rst_n), .i_max(SEC_MAX),
    .i_up(tmr_inc & (o_pos == POS_SEC)), .i_dn(t_dec),
    .o_val(t_sec), .o_wrap(t_sec_wrap));
  mod_cnt u_t_min (.clk(clk), .rst_n(rst_n), .i_max(MIN_MAX),
    .i_up(tmr_inc & (o_pos == POS_MIN)), .i_dn(t_dec & t_sec_wrap),
    .o_val(t_min), .o_wrap(t_min_wrap));

  assign unused_wraps = c_hour_wrap & t_min_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mode <= MODE_CLOCK;
      o_pos  <= POS_SEC;
    end else begin
      case (o_mode)
        MODE_CLOCK, MODE_SETUP, MODE_TIMER: begin
          if (i_mode_pls) begin
            o_mode <= (o_mode == MODE_TIMER) ? MODE_CLOCK : o_mode + 2'd1;
            o_pos  <= POS_SEC;
          end else if (pos_ev && o_mode == MODE_SETUP) begin
            o_pos <= (o_pos == POS_HOUR) ? POS_SEC : o_pos + 2'd1;
          end else if (pos_ev && tmr_edit) begin
            o_pos <= (o_pos == POS_SEC) ? POS_MIN : POS_SEC;
          end
        end
        default: begin
          o_mode <= MODE_CLOCK;
          o_pos  <= POS_SEC;
        end
      endcase
    end
  end

  // A stop request on the tick still decrements, since t_dec uses the pre-toggle run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              o_run <= 1'b0;
    else if (expire)                         o_run <= 1'b0;
    else if (run_ev && o_mode == MODE_TIMER) o_run <= ~o_run & ~t_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_buzz    <= 1'b0;
      buzz_left <= '0;
    end else if (expire) begin
      o_buzz    <= 1'b1;
      buzz_left <= BUZ_W'(BUZZ_SEC);
    end else if (any_pls) begin
      o_buzz <= 1'b0;
    end else if (o_buzz && tick) begin
      buzz_left <= buzz_left - 1'b1;
      if (buzz_left == BUZ_W'(1)) o_buzz <= 1'b0;
    end
  end

  always_comb begin
    o_disp_h = c_hour;
    o_disp_m = c_min;
    o_disp_s = c_sec;
    if (o_mode == MODE_TIMER) begin
      o_disp_h = '0;
      o_disp_m = t_min;
      o_disp_s = t_sec;
    end
  end

endmodule

// File: tb/tb_hms_clock_core.sv
// Scoreboard bench for hms_clock_core against a seconds-based reference model.
module tb_hms_clock_core;

  localparam int CLK_HZ   = 4;
  localparam int HOUR_MAX = 23;
  localparam int BUZZ_SEC = 5;
  localparam int DAY      = (HOUR_MAX + 1) * 3600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_p = 1'b0, pos_p = 1'b0, inc_p = 1'b0, run_p = 1'b0;
  logic [5:0] disp_h, disp_m, disp_s;
  logic [1:0] mode, pos;
  logic       run, buzz;

  hms_clock_core #(.CLK_HZ(CLK_HZ), .HOUR_MAX(HOUR_MAX), .BUZZ_SEC(BUZZ_SEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mode_pls(mode_p), .i_pos_pls(pos_p), .i_inc_pls(inc_p), .i_run_pls(run_p),
    .o_disp_h(disp_h), .o_disp_m(disp_m), .o_disp_s(disp_s),
    .o_mode(mode), .o_pos(pos), .o_run(run), .o_buzz(buzz)
  );

  always #5 clk = ~clk;

  typedef struct {int h; int m; int s; int mode; int pos; int run; int buzz;} exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: clock as seconds-of-day, timer as total seconds.
  int md_clk, md_tmr, md_mode, md_pos, md_run, md_buzz, md_left, md_div;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    md_clk = 0; md_tmr = 0; md_mode = 0; md_pos = 0;
    md_run = 0; md_buzz = 0; md_left = 0; md_div = 0;
  endfunction

  function automatic void model_step(input bit mp, input bit pp, input bit ip, input bit rp);
    bit tick, run_e, pos_e, inc_e, expire;
    int old_run, h, mi, s;
    tick    = (md_div == CLK_HZ - 1);
    md_div  = tick ? 0 : md_div + 1;
    run_e   = rp && !mp;
    pos_e   = pp && !mp && !rp;
    inc_e   = ip && !mp && !rp && !pp;
    expire  = 0;
    old_run = md_run;
    if (tick && md_mode != 1) md_clk = (md_clk + 1) % DAY;
    if (md_mode == 1 && inc_e) begin
      h = md_clk / 3600; mi = (md_clk / 60) % 60; s = md_clk % 60;
      case (md_pos)
        0: s = (s + 1) % 60;
        1: mi = (mi + 1) % 60;
        default: h = (h + 1) % (HOUR_MAX + 1);
      endcase
      md_clk = h * 3600 + mi * 60 + s;
    end
    if (old_run != 0 && tick) begin
      md_tmr--;
      expire = (md_tmr == 0);
    end
    if (md_mode == 2 && old_run == 0 && inc_e) begin
      if (md_pos == 0) md_tmr = (md_tmr / 60) * 60 + (md_tmr % 60 + 1) % 60;
      else             md_tmr = ((md_tmr / 60 + 1) % 60) * 60 + md_tmr % 60;
    end
    if (expire) md_run = 0;
    else if (run_e && md_mode == 2) md_run = (old_run != 0) ? 0 : int'(md_tmr != 0);
    if (expire) begin
      md_buzz = 1; md_left = BUZZ_SEC;
    end else if (mp || pp || ip || rp) begin
      md_buzz = 0;
    end else if (md_buzz != 0 && tick) begin
      md_left--;
      if (md_left == 0) md_buzz = 0;
    end
    if (mp) begin
      md_mode = (md_mode + 1) % 3; md_pos = 0;
    end else if (pos_e) begin
      if (md_mode == 1) md_pos = (md_pos + 1) % 3;
      else if (md_mode == 2 && old_run == 0) md_pos = (md_pos == 0) ? 1 : 0;
    end
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    if (md_mode == 2) begin
      e.h = 0; e.m = md_tmr / 60; e.s = md_tmr % 60;
    end else begin
      e.h = md_clk / 3600; e.m = (md_clk / 60) % 60; e.s = md_clk % 60;
    end
    e.mode = md_mode; e.pos = md_pos; e.run = md_run; e.buzz = md_buzz;
    return e;
  endfunction

  // Called at a negedge: drive one cycle of pulses, predict, and move to the next negedge.
  task automatic cyc(input bit mp, input bit pp, input bit ip, input bit rp);
    mode_p = mp; pos_p = pp; inc_p = ip; run_p = rp;
    model_step(mp, pp, ip, rp);
    q.push_back(model_view());
    @(negedge clk);
    mode_p = 0; pos_p = 0; inc_p = 0; run_p = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_h"}, disp_h, 0); chk({nm, "_m"}, disp_m, 0); chk({nm, "_s"}, disp_s, 0);
    chk({nm, "_mode"}, mode, 0); chk({nm, "_pos"}, pos, 0);
    chk({nm, "_run"}, run, 0); chk({nm, "_buzz"}, buzz, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("disp_h", disp_h, e.h); chk("disp_m", disp_m, e.m); chk("disp_s", disp_s, e.s);
      chk("mode", mode, e.mode); chk("pos", pos, e.pos);
      chk("run", run, e.run); chk("buzz", buzz, e.buzz);
    end
  end

  initial begin
    model_reset();
    #12 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Preload 23:59:58 in SETUP, then back to CLOCK through TIMER and roll over.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 58; k++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 23; k++) cyc(0, 0, 1, 0);
    chk("preload_h", disp_h, 23); chk("preload_m", disp_m, 59); chk("preload_s", disp_s, 58);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(8);

    // SETUP hour field wraps modulo HOUR_MAX+1; pos cycles back to SEC.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int k = 0; k < 25; k++) cyc(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    chk("pos_cycle", pos, 2);
    cyc(0, 1, 0, 0);

    // TIMER 01:02 countdown to expiry, buzzer then times out.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("tset_m", disp_m, 1); chk("tset_s", disp_s, 2);
    cyc(0, 0, 0, 1);
    idle(62 * CLK_HZ + BUZZ_SEC * CLK_HZ + 4);
    chk("texp_m", disp_m, 0); chk("texp_s", disp_s, 0); chk("buzz_done", buzz, 0);

    // Start at 00:00 is ignored; mode pulse masks a simultaneous inc.
    cyc(0, 0, 0, 1);
    chk("run_at_zero", run, 0);
    cyc(1, 0, 1, 0);
    chk("mode_wins", mode, 0);

    // Timer runs in CLOCK mode; buzzer cleared by a pos pulse.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 40 && md_buzz == 0; k++) cyc(0, 0, 0, 0);
    chk("buzz_rise", buzz, 1);
    cyc(0, 1, 0, 0);
    chk("buzz_clear", buzz, 0);

    // Asynchronous reset mid-countdown, then divider restarts from 0.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    idle(10);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= CLK_HZ; k++) begin
      cyc(0, 0, 0, 0);
      if (k == CLK_HZ - 1) chk("first_tick_early", disp_s, 0);
    end
    chk("first_tick", disp_s, 1);

    // Randomized pulses against the reference model.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
